// File: rtl/alu_seq.sv
// Multi-cycle ALU: registered single-cycle ops plus iterative unsigned
// multiply (shift-add) and divide (restoring) behind a start/done handshake.
module alu_seq #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Ctrl,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] res_hi,
  output logic             overflow,
  output logic             Co,
  output logic             zero,
  output logic [1:0]       dbg_state
);

  // Handshake: start is sampled only while busy=0 in IDLE; done is a one-cycle
  // pulse marking the edge at which res/res_hi/overflow/Co/zero were updated.

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_NOR  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_SLTU = 4'd10;
  localparam logic [3:0] OP_ADDU = 4'd11;
  localparam logic [3:0] OP_SUBU = 4'd12;
  localparam logic [3:0] OP_MULU = 4'd13;
  localparam logic [3:0] OP_DIVU = 4'd14;

  localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  state_t           state;
  logic [SHW:0]     cnt;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opnd;

  assign dbg_state = state;

  // Single-cycle datapath
  logic [SHW-1:0]   shamt;
  logic             is_sub;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] sc_res;
  logic             sc_ovf;
  logic             sc_co;

  assign shamt  = B[SHW-1:0];
  assign is_sub = (ALU_Ctrl == OP_SUB) || (ALU_Ctrl == OP_SUBU);
  assign sum    = {1'b0, A} + {1'b0, (is_sub ? ~B : B)} + {{WIDTH{1'b0}}, is_sub};

  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    sc_co  = 1'b0;
    case (ALU_Ctrl)
      OP_AND:  sc_res = A & B;
      OP_OR:   sc_res = A | B;
      OP_XOR:  sc_res = A ^ B;
      OP_NOR:  sc_res = ~(A | B);
      OP_SRL:  sc_res = A >> shamt;
      OP_SLL:  sc_res = A << shamt;
      OP_SRA:  sc_res = $signed(A) >>> shamt;
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_ADD: begin
        sc_res = sum[WIDTH-1:0];
        sc_co  = sum[WIDTH];
        sc_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = sum[WIDTH-1:0];
        sc_co  = sum[WIDTH];
        sc_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_ADDU, OP_SUBU: begin
        sc_res = sum[WIDTH-1:0];
        sc_co  = sum[WIDTH];
      end
      default: sc_res = '0;
    endcase
  end

  // Multiply step: {acc_hi,acc_lo} holds partial product over remaining multiplier bits
  logic [WIDTH:0]   mul_add;
  logic [WIDTH-1:0] mul_hi_n;
  logic [WIDTH-1:0] mul_lo_n;

  assign mul_add  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
  assign mul_hi_n = mul_add[WIDTH:1];
  assign mul_lo_n = {mul_add[0], acc_lo[WIDTH-1:1]};

  // Divide step: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in
  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_trial;
  logic             div_ge;
  logic [WIDTH-1:0] div_hi_n;
  logic [WIDTH-1:0] div_lo_n;

  assign div_sh    = {acc_hi, acc_lo[WIDTH-1]};
  assign div_trial = div_sh - {1'b0, opnd};
  assign div_ge    = ~div_trial[WIDTH];
  assign div_hi_n  = div_ge ? div_trial[WIDTH-1:0] : div_sh[WIDTH-1:0];
  assign div_lo_n  = {acc_lo[WIDTH-2:0], div_ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      res      <= '0;
      res_hi   <= '0;
      overflow <= 1'b0;
      Co       <= 1'b0;
      zero     <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (ALU_Ctrl == OP_MULU) begin
              state  <= ST_MUL;
              cnt    <= CNT_INIT;
              acc_hi <= '0;
              acc_lo <= B;
              opnd   <= A;
              busy   <= 1'b1;
            end else if (ALU_Ctrl == OP_DIVU && B != '0) begin
              state  <= ST_DIV;
              cnt    <= CNT_INIT;
              acc_hi <= '0;
              acc_lo <= A;
              opnd   <= B;
              busy   <= 1'b1;
            end else if (ALU_Ctrl == OP_DIVU) begin
              res      <= '1;
              res_hi   <= A;
              overflow <= 1'b1;
              Co       <= 1'b0;
              zero     <= 1'b0;
              done     <= 1'b1;
            end else begin
              res      <= sc_res;
              res_hi   <= '0;
              overflow <= sc_ovf;
              Co       <= sc_co;
              zero     <= (sc_res == '0);
              done     <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          acc_hi <= mul_hi_n;
          acc_lo <= mul_lo_n;
          cnt    <= cnt - CNT_LAST;
          if (cnt == CNT_LAST) begin
            res      <= mul_lo_n;
            res_hi   <= mul_hi_n;
            overflow <= 1'b0;
            Co       <= 1'b0;
            zero     <= (mul_lo_n == '0);
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        ST_DIV: begin
          acc_hi <= div_hi_n;
          acc_lo <= div_lo_n;
          cnt    <= cnt - CNT_LAST;
          if (cnt == CNT_LAST) begin
            res      <= div_lo_n;
            res_hi   <= div_hi_n;
            overflow <= 1'b0;
            Co       <= 1'b0;
            zero     <= (div_lo_n == '0);
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vector table, randomized ops against a
// high-level arithmetic model, reset/abort and WIDTH=8 corner cases.
module tb_alu_seq;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic           start;
  logic [W-1:0]   a, b;
  logic [3:0]     ctrl;
  logic           busy, done, ovf, co, zero;
  logic [W-1:0]   res, res_hi;
  logic [1:0]     dbg_state;

  logic           start8;
  logic [7:0]     a8, b8;
  logic [3:0]     ctrl8;
  logic           busy8, done8, ovf8, co8, zero8;
  logic [7:0]     res8, res_hi8;
  logic [1:0]     dbg_state8;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(a), .B(b), .ALU_Ctrl(ctrl),
    .busy(busy), .done(done), .res(res), .res_hi(res_hi), .overflow(ovf),
    .Co(co), .zero(zero), .dbg_state(dbg_state)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8), .ALU_Ctrl(ctrl8),
    .busy(busy8), .done(done8), .res(res8), .res_hi(res_hi8), .overflow(ovf8),
    .Co(co8), .zero(zero8), .dbg_state(dbg_state8)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [66:0] exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain arithmetic on the operation definitions
  typedef struct packed {
    logic [W-1:0] r;
    logic [W-1:0] h;
    logic         ov;
    logic         c;
  } exp_t;

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    longint sa, sb, sr;
    logic signed [W-1:0] rs;
    logic [63:0] p;
    int sh;
    e  = '0;
    sa = $signed(x);
    sb = $signed(y);
    sh = int'(y % W);
    case (op)
      4'd0:  e.r = x & y;
      4'd1:  e.r = x | y;
      4'd2, 4'd11: begin
        e.r = x + y;
        e.c = ({32'd0, x} + {32'd0, y}) > 64'hFFFF_FFFF;
        sr  = sa + sb;
        rs  = e.r;
        if (op == 4'd2) e.ov = (sr != rs);
      end
      4'd3:  e.r = x ^ y;
      4'd4:  e.r = ~(x | y);
      4'd5:  e.r = x >> sh;
      4'd6, 4'd12: begin
        e.r = x - y;
        e.c = (x >= y);
        sr  = sa - sb;
        rs  = e.r;
        if (op == 4'd6) e.ov = (sr != rs);
      end
      4'd7:  e.r = (sa < sb) ? 1 : 0;
      4'd8:  e.r = x << sh;
      4'd9:  e.r = $signed(x) >>> sh;
      4'd10: e.r = (x < y) ? 1 : 0;
      4'd13: begin
        p   = {32'd0, x} * {32'd0, y};
        e.r = p[31:0];
        e.h = p[63:32];
      end
      4'd14: begin
        if (y == 0) begin
          e.r  = '1;
          e.h  = x;
          e.ov = 1'b1;
        end else begin
          e.r = x / y;
          e.h = x % y;
        end
      end
      default: e.r = '0;
    endcase
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one op; returns edges until done and the number of busy cycles seen before it.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit noise, output int lat, output int bcnt);
    start = 1'b1; a = x; b = y; ctrl = op;
    tick();
    start = 1'b0;
    lat = 1;
    bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        a = $urandom;
        b = $urandom;
        ctrl = 4'($urandom_range(0, 15));
      end
      tick();
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic run_op8(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y, output int lat);
    start8 = 1'b1; a8 = x; b8 = y; ctrl8 = op;
    tick();
    start8 = 1'b0;
    lat = 1;
    while (!done8 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a, b, r, h;
    logic         ov, c;
    int           lat;
  } vec_t;

  vec_t vecs[17];

  initial begin
    int lat, bcnt, ndone;
    exp_t e;
    logic [3:0] op;
    logic [W-1:0] x, y;
    logic [66:0] got, want;

    vecs[0]  = '{4'd2,  32'd3,          32'd4,          32'd7,          32'd0,          1'b0, 1'b0, 1};
    vecs[1]  = '{4'd2,  32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  32'd0,          1'b1, 1'b0, 1};
    vecs[2]  = '{4'd6,  32'd0,          32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 1'b0, 1};
    vecs[3]  = '{4'd11, 32'hFFFF_FFFF,  32'd1,          32'd0,          32'd0,          1'b0, 1'b1, 1};
    vecs[4]  = '{4'd7,  32'h8000_0000,  32'd1,          32'd1,          32'd0,          1'b0, 1'b0, 1};
    vecs[5]  = '{4'd10, 32'h8000_0000,  32'd1,          32'd0,          32'd0,          1'b0, 1'b0, 1};
    vecs[6]  = '{4'd9,  32'h8000_0000,  32'd31,         32'hFFFF_FFFF,  32'd0,          1'b0, 1'b0, 1};
    vecs[7]  = '{4'd8,  32'd5,          32'd33,         32'd10,         32'd0,          1'b0, 1'b0, 1};
    vecs[8]  = '{4'd13, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFE,  1'b0, 1'b0, 33};
    vecs[9]  = '{4'd14, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 1'b0, 33};
    vecs[10] = '{4'd14, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 1'b0, 1};
    vecs[11] = '{4'd15, 32'd5,          32'd6,          32'd0,          32'd0,          1'b0, 1'b0, 1};
    vecs[12] = '{4'd5,  32'h8000_0000,  32'd4,          32'h0800_0000,  32'd0,          1'b0, 1'b0, 1};
    vecs[13] = '{4'd4,  32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0,          1'b0, 1'b0, 1};
    vecs[14] = '{4'd6,  32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  32'd0,          1'b1, 1'b1, 1};
    vecs[15] = '{4'd13, 32'd0,          32'd12345,      32'd0,          32'd0,          1'b0, 1'b0, 33};
    vecs[16] = '{4'd2,  32'hFFFF_FFFF,  32'd1,          32'd0,          32'd0,          1'b0, 1'b1, 1};

    rst_n = 1'b0;
    start = 1'b0; a = '0; b = '0; ctrl = '0;
    start8 = 1'b0; a8 = '0; b8 = '0; ctrl8 = '0;

    // Reset state
    #12;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst res", res, 0);
    check("rst res_hi", res_hi, 0);
    check("rst ovf", ovf, 0);
    check("rst co", co, 0);
    check("rst zero", zero, 1);
    check("rst state", dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Directed table; start noise injected while busy must be ignored
    for (int i = 0; i < 17; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lat > 1, lat, bcnt);
      check($sformatf("v%0d lat", i), lat, vecs[i].lat);
      check($sformatf("v%0d busy_cycles", i), bcnt, vecs[i].lat - 1);
      check($sformatf("v%0d busy_at_done", i), busy, 0);
      check($sformatf("v%0d res", i), res, vecs[i].r);
      check($sformatf("v%0d res_hi", i), res_hi, vecs[i].h);
      check($sformatf("v%0d ovf", i), ovf, vecs[i].ov);
      check($sformatf("v%0d co", i), co, vecs[i].c);
      check($sformatf("v%0d zero", i), zero, vecs[i].r == 0);
      tick();
      check($sformatf("v%0d done_pulse", i), done, 0);
      check($sformatf("v%0d hold", i), res, vecs[i].r);
    end

    // Random back-to-back single-cycle ops, one per cycle
    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 13));
      if (op == 4'd13) op = 4'd15;
      x = $urandom;
      y = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 40)) : W'($urandom);
      start = 1'b1; a = x; b = y; ctrl = op;
      e = model(op, x, y);
      exp_q.push_back({e.r, e.h, e.ov, e.c, (e.r == 0)});
      tick();
      want = exp_q.pop_front();
      got  = {res, res_hi, ovf, co, zero};
      check($sformatf("b2b%0d op%0d done", i, op), done, 1);
      check($sformatf("b2b%0d op%0d out", i, op), got, want);
    end
    start = 1'b0;
    tick();

    // Random multiply/divide against the model
    for (int i = 0; i < 24; i++) begin
      op = (i % 2 == 0) ? 4'd13 : 4'd14;
      x = $urandom;
      case ($urandom_range(0, 3))
        0: y = W'($urandom_range(0, 9));
        1: y = W'($urandom_range(0, 65535));
        default: y = $urandom;
      endcase
      e = model(op, x, y);
      run_op(op, x, y, 1'b1, lat, bcnt);
      check($sformatf("rnd%0d op%0d lat", i, op), lat, (op == 4'd14 && y == 0) ? 1 : W + 1);
      check($sformatf("rnd%0d op%0d out", i, op), {res, res_hi, ovf, co, zero},
            {e.r, e.h, e.ov, e.c, (e.r == 0)});
      tick();
    end

    // Reset in the middle of a multiply aborts without done
    start = 1'b1; a = 32'h1234_5678; b = 32'h9ABC_DEF0; ctrl = 4'd13;
    tick();
    start = 1'b0;
    repeat (10) tick();
    check("mid busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort busy", busy, 0);
    check("abort res", res, 0);
    check("abort res_hi", res_hi, 0);
    check("abort zero", zero, 1);
    check("abort done", done, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) ndone++;
    end
    check("abort no_done", ndone, 0);
    check("abort idle_busy", busy, 0);
    run_op(4'd2, 32'd3, 32'd4, 1'b0, lat, bcnt);
    check("post_rst add lat", lat, 1);
    check("post_rst add res", res, 7);
    tick();
    check("post_rst add pulse", done, 0);

    // WIDTH=8 instance
    run_op8(4'd13, 8'd200, 8'd3, lat);
    check("w8 mul lat", lat, 9);
    check("w8 mul prod", {res_hi8, res8}, 16'h0258);
    check("w8 mul busy", busy8, 0);
    tick();
    run_op8(4'd14, 8'd200, 8'd7, lat);
    check("w8 div lat", lat, 9);
    check("w8 div q_r", {res8, res_hi8}, {8'd28, 8'd4});
    tick();
    run_op8(4'd2, 8'h7F, 8'd1, lat);
    check("w8 add lat", lat, 1);
    check("w8 add out", {res8, ovf8, co8}, {8'h80, 1'b1, 1'b0});
    run_op8(4'd14, 8'd9, 8'd0, lat);
    check("w8 div0 out", {lat[3:0], res8, res_hi8, ovf8}, {4'd1, 8'hFF, 8'd9, 1'b1});
    for (int i = 0; i < 8; i++) begin
      logic [7:0] x8, y8;
      logic [15:0] p8;
      x8 = 8'($urandom);
      y8 = 8'($urandom);
      p8 = {8'd0, x8} * {8'd0, y8};
      tick();
      run_op8(4'd13, x8, y8, lat);
      check($sformatf("w8 rmul%0d", i), {lat[3:0], res_hi8, res8}, {4'd9, p8});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised multi-cycle ALU, successor to the 32-bit single-cycle datapath ALU. It keeps the 4-bit operation encoding for all single-cycle operations, registers every result, and adds iterative unsigned multiply and divide behind a start/done handshake. The CPU datapath stalls on `busy`. All outputs are registered and stay stable between operations.

## Interface
- `WIDTH`, 32: operand/result width; power of two, ≥ 8.
- `SHW`, $clog2(WIDTH): shift-amount width; derived, not overridden.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only while `busy`=0.
- `A`, `B`  in  WIDTH  operands; latched on an accepted start.
- `ALU_Ctrl`  in  4  operation select; latched on an accepted start.
- `busy`  out  1  high from the cycle after acceptance until `done`.
- `done`  out  1  one-cycle pulse when the result becomes valid.
- `res`  out  WIDTH  result; low product or quotient for multiply/divide.
- `res_hi`  out  WIDTH  high product or remainder; 0 for all other ops.
- `overflow`  out  1  signed overflow (add/sub) or divide-by-zero.
- `Co`  out  1  carry out of the adder.
- `zero`  out  1  `res` == 0.

## Operation
- Encoding:
  - 0 AND
  - 1 OR
  - 2 ADD
  - 3 XOR
  - 4 NOR
  - 5 SRL (A >> B[SHW-1:0])
  - 6 SUB
  - 7 SLT (signed A<B → 1, else 0)
  - 8 SLL
  - 9 SRA
  - 10 SLTU (unsigned)
  - 11 ADDU
  - 12 SUBU
  - 13 MULTU
  - 14 DIVU
  - 15 reserved → `res`=0
- SLT uses a true signed comparison, not the sign bit of the difference.
- Adder: sum = A + (sub ? ~B : B) + sub, computed over WIDTH+1 bits. `Co` = bit WIDTH, updated for ops 2, 6, 11, 12 and 0 otherwise.
- `overflow`:
  - ops 2/6: signed overflow, operand signs equal (ADD) or different (SUB) and result sign different from A.
  - op 14: set when B==0.
  - all other ops: 0.
- FSM states: IDLE, MUL, DIV.
  - IDLE, accepted start with ops 0–12 or 15: compute, register outputs, pulse `done` next edge, stay in IDLE.
  - IDLE, accepted start with op 13: → MUL, counter = WIDTH.
  - IDLE, accepted start with op 14 and B≠0: → DIV, counter = WIDTH.
  - IDLE, accepted start with op 14 and B==0: no iteration. `res`=all ones, `res_hi`=A, `overflow`=1, `done` next edge.
- MUL: shift-add, one multiplier bit per cycle, 2·WIDTH-bit accumulator. When counter reaches 0: `res`={low}, `res_hi`={high}, pulse `done`, → IDLE.
- DIV: restoring, one quotient bit per cycle. When counter reaches 0: `res`=quotient, `res_hi`=remainder, pulse `done`, → IDLE.
- `zero` is computed from the final `res` and registered with it.
- `start` while `busy`=1 is ignored. Operands are not re-sampled during iteration.

## Timing
- Reset (async, `rst_n`=0): state IDLE. `busy`, `done`, `res`, `res_hi`, `overflow`, `Co` = 0. `zero` = 1. Counter = 0.
- Reset mid-iteration aborts immediately. No `done` is produced.
- Single-cycle ops and DIVU-by-zero: start accepted at edge k, `done`=1 and results valid after edge k+1. `busy` never rises.
- MULTU/DIVU: `busy`=1 after edge k+1 through edge k+WIDTH. `done`=1 and results valid after edge k+WIDTH+1, with `busy`=0 in the same cycle.
- `start` high in the `done` cycle is accepted (back-to-back). Throughput: 1 op/cycle for single-cycle ops.
- Outputs hold their last values until the next `done`. `done` is low in all other cycles.

## Test plan
- Reset: assert `rst_n`=0 mid-MULTU → `busy`=0, `res`=0, `zero`=1. Release and issue ADD 3+4 → `res`=7 one cycle after start, `done` 1 cycle.
- ADD 0x7FFFFFFF+1 → `res`=0x80000000, `overflow`=1, `Co`=0. SUB 0 − 1 → `res`=0xFFFFFFFF, `Co`=0. ADDU 0xFFFFFFFF+1 → `res`=0, `zero`=1, `Co`=1, `overflow`=0.
- SLT A=0x80000000, B=1 → `res`=1. SLTU same operands → 0. SRA 0x80000000 by 31 → 0xFFFFFFFF. SLL by B=33 → shift by 1.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → `res`=0x00000001, `res_hi`=0xFFFFFFFE. `done` exactly 33 cycles after start. `start` pulses during busy are ignored.
- DIVU 100/7 → `res`=14, `res_hi`=2 after 33 cycles. DIVU 5/0 → `res`=0xFFFFFFFF, `res_hi`=5, `overflow`=1 after 1 cycle.
- WIDTH=8 instance: MULTU 200×3 → {`res_hi`,`res`}=0x0258, `done` after 9 cycles. Random single-cycle ops back-to-back match the reference model every cycle.
